// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for a five-stage in-order core. It turns the
// hazard conditions seen in ID/EX/MEM into stage-register load enables and
// bubble (flush) controls. All outputs are combinational from the current
// state and the inputs, so a hazard is acted on in the same cycle it appears.
//
// Parameters
//   REDIRECT_PENALTY  extra fetch-bubble cycles after a redirect (0..7)
//   MEM_TIMEOUT       consecutive mem_busy_i cycles before err_o sets (1..65535)
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   id_rs1_i, id_rs2_i     source registers of the instruction in ID
//   ex_rd_i                destination register of the instruction in EX
//   ex_mem_read_i          EX instruction is a load
//   ex_redirect_i          taken branch / jump / return resolved in EX
//   mem_busy_i             data memory not ready this cycle
//   pc_en_o .. mem_wb_en_o stage register load enables
//   if_id_flush_o          load a bubble into IF/ID
//   id_ex_flush_o          load a bubble into ID/EX
//   state_o                current FSM state
//   err_o                  sticky memory-timeout flag
//
// Optional feature (macro HAZARD_CTRL_PERF_EN)
//   stall_cnt_o     load-use stall cycles
//   redirect_cnt_o  redirects accepted
//   busy_cnt_o      freeze cycles
//   All three saturate at 32'hFFFFFFFF and are zeroed by reset.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal flow; load-use stalls handled without a state change
// PENALTY  | fetch bubbles after a redirect; pen_cnt_q cycles remain
// MEM_WAIT | pipeline frozen on mem_busy_i; pen_cnt_q keeps the penalty
//          | count that was pending when the freeze began
// 2'b11    | unreachable; recovers to RUN on the next edge
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int unsigned REDIRECT_PENALTY = 1,
  parameter int unsigned MEM_TIMEOUT      = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_mem_read_i,
  input  logic        ex_redirect_i,
  input  logic        mem_busy_i,
  output logic        pc_en_o,
  output logic        if_id_en_o,
  output logic        id_ex_en_o,
  output logic        ex_mem_en_o,
  output logic        mem_wb_en_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic [1:0]  state_o,
  output logic        err_o
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] redirect_cnt_o,
  output logic [31:0] busy_cnt_o
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    PENALTY  = 2'b01,
    MEM_WAIT = 2'b10,
    ILLEGAL  = 2'b11
  } state_e;

  localparam logic [2:0]  PEN_LOAD = 3'(REDIRECT_PENALTY);
  localparam logic [15:0] TIMEOUT  = 16'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [2:0]  pen_cnt_q, pen_cnt_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        err_q, err_d;

  logic        load_use;
  logic        in_penalty;
  logic        ev_stall, ev_redirect, ev_busy;

  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush;

  // A load whose destination is read by the instruction in ID. x0 is never
  // a real dependency, so it cannot stall.
  assign load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                    ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

  // Leaving MEM_WAIT behaves like whichever state the freeze interrupted,
  // which is recoverable from the preserved penalty count alone.
  always_comb begin
    in_penalty = 1'b0;
    case (state_q)
      PENALTY:  in_penalty = 1'b1;
      MEM_WAIT: in_penalty = (pen_cnt_q != 3'd0);
      default:  in_penalty = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pen_cnt_d   = pen_cnt_q;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ev_stall    = 1'b0;
    ev_redirect = 1'b0;
    ev_busy     = 1'b0;

    if (mem_busy_i) begin
      // Freeze: nothing moves and nothing is flushed, so the pipeline
      // contents survive the wait untouched.
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      ev_busy   = 1'b1;
      if (state_q == ILLEGAL) begin
        state_d   = RUN;
        pen_cnt_d = 3'd0;
      end else begin
        state_d = MEM_WAIT;
      end
    end else if (state_q == ILLEGAL) begin
      state_d   = RUN;
      pen_cnt_d = 3'd0;
    end else if (ex_redirect_i) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      ev_redirect = 1'b1;
      pen_cnt_d   = PEN_LOAD;
      state_d     = (PEN_LOAD != 3'd0) ? PENALTY : RUN;
    end else if (in_penalty) begin
      // ID only ever holds a bubble here, so load-use is not evaluated.
      if_id_flush = 1'b1;
      pen_cnt_d   = pen_cnt_q - 3'd1;
      state_d     = (pen_cnt_q == 3'd1) ? RUN : PENALTY;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      ev_stall    = 1'b1;
      state_d     = RUN;
    end else begin
      state_d = RUN;
    end
  end

  // Watchdog counts consecutive busy cycles and saturates at the timeout.
  always_comb begin
    wd_cnt_d = 16'd0;
    if (mem_busy_i) begin
      wd_cnt_d = (wd_cnt_q >= TIMEOUT) ? wd_cnt_q : (wd_cnt_q + 16'd1);
    end
    err_d = err_q || (wd_cnt_d == TIMEOUT);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RUN;
      pen_cnt_q <= 3'd0;
      wd_cnt_q  <= 16'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pen_cnt_q <= pen_cnt_d;
      wd_cnt_q  <= wd_cnt_d;
      err_q     <= err_d;
    end
  end

  // While reset is held every stage loads a bubble and nothing advances.
  always_comb begin
    if (!rst_ni) begin
      pc_en_o       = 1'b0;
      if_id_en_o    = 1'b0;
      id_ex_en_o    = 1'b0;
      ex_mem_en_o   = 1'b0;
      mem_wb_en_o   = 1'b0;
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else begin
      pc_en_o       = pc_en;
      if_id_en_o    = if_id_en;
      id_ex_en_o    = id_ex_en;
      ex_mem_en_o   = ex_mem_en;
      mem_wb_en_o   = mem_wb_en;
      if_id_flush_o = if_id_flush;
      id_ex_flush_o = id_ex_flush;
    end
  end

  assign state_o = state_q;
  assign err_o   = err_q;

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, redirect_cnt_q, busy_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q    <= 32'd0;
      redirect_cnt_q <= 32'd0;
      busy_cnt_q     <= 32'd0;
    end else begin
      if (ev_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (ev_redirect && (redirect_cnt_q != 32'hFFFF_FFFF)) begin
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
      if (ev_busy && (busy_cnt_q != 32'hFFFF_FFFF)) begin
        busy_cnt_q <= busy_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt_o    = stall_cnt_q;
  assign redirect_cnt_o = redirect_cnt_q;
  assign busy_cnt_o     = busy_cnt_q;
`else
  logic unused_ev;
  assign unused_ev = ev_stall ^ ev_redirect ^ ev_busy;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int RP = 2;
  localparam int MT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0;
  logic       mr = 1'b0, rdr = 1'b0, busy = 1'b0;

  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, err;
  logic [1:0] state;
`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt, redirect_cnt, busy_cnt;
`endif

  int total = 0;
  int bad = 0;
  bit run_chk = 1'b0;

  hazard_ctrl #(.REDIRECT_PENALTY(RP), .MEM_TIMEOUT(MT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .ex_rd_i(rd),
    .ex_mem_read_i(mr), .ex_redirect_i(rdr), .mem_busy_i(busy),
    .pc_en_o(pc_en), .if_id_en_o(if_id_en), .id_ex_en_o(id_ex_en),
    .ex_mem_en_o(ex_mem_en), .mem_wb_en_o(mem_wb_en),
    .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush),
    .state_o(state), .err_o(err)
`ifdef HAZARD_CTRL_PERF_EN
    , .stall_cnt_o(stall_cnt), .redirect_cnt_o(redirect_cnt), .busy_cnt_o(busy_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Output vector: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
  logic [6:0] vec;
  assign vec = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining fetch bubbles, freeze flag, busy run length.
  int m_pen = 0;
  bit m_wait = 0;
  int m_wd = 0;
  bit m_err = 0;
  int m_stall = 0, m_redir = 0, m_busyc = 0;

  function automatic bit lu_now();
    return mr && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

  function automatic logic [6:0] exp_vec();
    if (!rst_n)       return 7'b0000011;
    if (busy)         return 7'b0000000;
    if (rdr)          return 7'b1111111;
    if (m_pen > 0)    return 7'b1111110;
    if (lu_now())     return 7'b0011101;
    return 7'b1111100;
  endfunction

  function automatic logic [1:0] exp_state();
    if (m_wait)    return 2'b10;
    if (m_pen > 0) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pen = 0; m_wait = 0; m_wd = 0; m_err = 0;
      m_stall = 0; m_redir = 0; m_busyc = 0;
    end else begin
      if (busy) begin
        m_wait = 1;
        m_busyc++;
      end else begin
        m_wait = 0;
        if (rdr) begin
          m_redir++;
          m_pen = RP;
        end else if (m_pen > 0) begin
          m_pen--;
        end else if (lu_now()) begin
          m_stall++;
        end
      end
      m_wd = busy ? ((m_wd < MT) ? m_wd + 1 : MT) : 0;
      if (m_wd >= MT) m_err = 1;
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      chk("model_vec", {25'd0, vec}, {25'd0, exp_vec()});
      chk("model_state", {30'd0, state}, {30'd0, exp_state()});
      chk("model_err", {31'd0, err}, {31'd0, m_err});
`ifdef HAZARD_CTRL_PERF_EN
      chk("model_stall_cnt", stall_cnt, m_stall);
      chk("model_redir_cnt", redirect_cnt, m_redir);
      chk("model_busy_cnt", busy_cnt, m_busyc);
`endif
    end
  end

  // Drive one cycle's inputs just after a rising edge, return mid-cycle.
  task automatic cyc(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                     input logic ld, input logic re, input logic bz);
    @(posedge clk);
    #1;
    rs1 = a; rs2 = b; rd = d; mr = ld; rdr = re; busy = bz;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    #2 rst_n = 1'b0;
    run_chk = 1'b1;
    idle();
    chk("rst_vec", {25'd0, vec}, 32'h03);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;

    idle();
    chk("default_vec", {25'd0, vec}, 32'h7C);

    // Load-use on rs2, then default the cycle after.
    cyc(5'd3, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("lu_rs2_vec", {25'd0, vec}, 32'h1D);
    chk("lu_rs2_state", {30'd0, state}, 32'd0);
    idle();
    chk("lu_after_vec", {25'd0, vec}, 32'h7C);
    // x0 destination never stalls.
    cyc(5'd0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("lu_x0_vec", {25'd0, vec}, 32'h7C);
    // Match on rs1, and a match without a load.
    cyc(5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("lu_rs1_vec", {25'd0, vec}, 32'h1D);
    cyc(5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0);
    chk("no_load_vec", {25'd0, vec}, 32'h7C);

    // Redirect pulse: one double flush, two penalty cycles, back to RUN.
    cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0);
    chk("redir_vec", {25'd0, vec}, 32'h7F);
    idle();
    chk("pen1_vec", {25'd0, vec}, 32'h7E);
    chk("pen1_state", {30'd0, state}, 32'd1);
    idle();
    chk("pen2_vec", {25'd0, vec}, 32'h7E);
    idle();
    chk("run_after_pen_vec", {25'd0, vec}, 32'h7C);
    chk("run_after_pen_state", {30'd0, state}, 32'd0);

    // Redirect inside PENALTY reloads the count.
    cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0);
    idle();
    cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0);
    chk("redir_in_pen_vec", {25'd0, vec}, 32'h7F);
    idle();
    idle();
    chk("reload_pen_state", {30'd0, state}, 32'd1);
    idle();
    chk("reload_done_state", {30'd0, state}, 32'd0);

    // Busy for 4 cycles while PENALTY has one bubble left.
    cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0);
    idle();
    for (int i = 0; i < 4; i++) begin
      cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
      chk("freeze_vec", {25'd0, vec}, 32'h00);
    end
    chk("freeze_state", {30'd0, state}, 32'd2);
    idle();
    chk("post_freeze_pen_vec", {25'd0, vec}, 32'h7E);
    chk("post_freeze_state", {30'd0, state}, 32'd2);
    idle();
    chk("post_freeze_run_vec", {25'd0, vec}, 32'h7C);
    chk("post_freeze_run_state", {30'd0, state}, 32'd0);
    chk("err_after_long_busy", {31'd0, err}, 32'd1);

    // Watchdog: three busy cycles set err after the third edge.
    do_reset();
    chk("err_cleared", {31'd0, err}, 32'd0);
    cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
    cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
    cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
    chk("err_two_edges", {31'd0, err}, 32'd0);
    // Leaving MEM_WAIT with no pending bubble behaves as RUN: load-use stalls.
    cyc(5'd9, 5'd1, 5'd9, 1'b1, 1'b0, 1'b0);
    chk("err_set", {31'd0, err}, 32'd1);
    chk("memwait_run_lu_vec", {25'd0, vec}, 32'h1D);
    idle();
    idle();
    chk("err_held", {31'd0, err}, 32'd1);
    // Two busy cycles after clearing must not retrigger anything new.
    do_reset();
    cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
    cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
    idle();
    chk("err_short_busy", {31'd0, err}, 32'd0);

    // Asynchronous reset in the middle of PENALTY.
    cyc(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", {30'd0, state}, 32'd0);
    chk("async_rst_vec", {25'd0, vec}, 32'h03);
    idle();
    rst_n = 1'b1;
    idle();
    chk("after_async_rst_vec", {25'd0, vec}, 32'h7C);
    chk("after_async_rst_state", {30'd0, state}, 32'd0);

    // Redirect together with load-use resolves as redirect.
    do_reset();
    cyc(5'd6, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0);
    chk("redir_lu_vec", {25'd0, vec}, 32'h7F);
    idle();
    chk("redir_lu_state", {30'd0, state}, 32'd1);
`ifdef HAZARD_CTRL_PERF_EN
    chk("redir_lu_redir_cnt", redirect_cnt, 32'd1);
    chk("redir_lu_stall_cnt", stall_cnt, 32'd0);
`endif
    idle();
    idle();

    // Mixed stimulus, checked cycle by cycle against the model.
    for (int i = 0; i < 300; i++) begin
      cyc(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 5) == 0));
    end
    idle();
    idle();

    run_chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REDIRECT_PENALTY, default 1, extra fetch-bubble cycles after a redirect, legal range 0..7.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, consecutive mem_busy_i cycles before err_o sets, legal range 1..65535.
REQ-003 SHALL have clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have id_rs1_i and id_rs2_i, input, 5 each, source registers of the instruction in ID.
REQ-006 SHALL have ex_rd_i, input, 5, destination register of the instruction in EX.
REQ-007 SHALL have ex_mem_read_i, input, 1, EX instruction is a load.
REQ-008 SHALL have ex_redirect_i, input, 1, taken branch, jump or return resolved in EX.
REQ-009 SHALL have mem_busy_i, input, 1, data memory not ready this cycle.
REQ-010 SHALL have pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o and mem_wb_en_o, output, 1 each, stage register load enables.
REQ-011 SHALL have if_id_flush_o and id_ex_flush_o, output, 1 each, load a bubble (all control fields 0) into that register.
REQ-012 SHALL have state_o, output, 2, current FSM state; err_o, output, 1, sticky memory-timeout flag.

Function
REQ-013 SHALL implement states RUN=2'b00, PENALTY=2'b01, MEM_WAIT=2'b10; encoding 2'b11 SHALL return to RUN on the next edge.
REQ-014 Outputs SHALL be combinational from current state and inputs (zero-cycle latency); only state, counters and err_o SHALL be registered.
REQ-015 Default decode (no hazard) SHALL be all enables 1, all flushes 0.
REQ-016 Priority SHALL be mem_busy_i > ex_redirect_i > load-use.
REQ-017 Freeze: mem_busy_i=1 in any state SHALL drive all enables 0 and all flushes 0.
REQ-018 In RUN or PENALTY, mem_busy_i=1 SHALL move to MEM_WAIT, saving the interrupted state's penalty count unchanged.
REQ-019 In MEM_WAIT with mem_busy_i=0, decode SHALL equal RUN decode if the saved count is 0, else PENALTY decode, and next state follows that decode.
REQ-020 Redirect (RUN, no busy): pc_en_o=1, if_id_flush_o=1, id_ex_flush_o=1, other enables 1; next state PENALTY with count=REDIRECT_PENALTY if nonzero, else RUN.
REQ-021 PENALTY (no busy): if_id_flush_o=1, all enables 1; count decrements; exit to RUN when count reaches 0.
REQ-022 ex_redirect_i in PENALTY SHALL be handled as in REQ-020 and reload the count.
REQ-023 Load-use: ex_mem_read_i=1, ex_rd_i!=0 and ex_rd_i equal to id_rs1_i or id_rs2_i SHALL give pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1, ex_mem_en_o=1, mem_wb_en_o=1 for that cycle, with no state change.
REQ-024 ex_rd_i=0 SHALL never raise a load-use stall.
REQ-025 Redirect and load-use together SHALL resolve as redirect only.
REQ-026 Watchdog SHALL count consecutive mem_busy_i=1 cycles, saturating, and clear on mem_busy_i=0; err_o SHALL set when the count reaches MEM_TIMEOUT and hold until reset.

Reset
REQ-027 While rst_ni=0: state RUN, counts 0, err_o 0, all enables 0, both flushes 1, state_o 2'b00.
REQ-028 Reset assertion mid-PENALTY or mid-MEM_WAIT SHALL abort immediately; the first edge after release SHALL be RUN with zero counts.

Configuration
REQ-029 Macro HAZARD_CTRL_PERF_EN defined SHALL add 32-bit outputs stall_cnt_o (load-use cycles), redirect_cnt_o (redirects) and busy_cnt_o (freeze cycles), saturating at 32'hFFFFFFFF and zeroed by reset.
REQ-030 Without HAZARD_CTRL_PERF_EN, those ports and counters SHALL not exist and all other behaviour SHALL be identical.

Verification
REQ-031 ex_mem_read_i=1, ex_rd_i=5, id_rs2_i=5 for one cycle -> pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1 that cycle; default decode the next cycle.
REQ-032 Same as REQ-031 with ex_rd_i=0, id_rs1_i=0 -> no stall, default decode.
REQ-033 REDIRECT_PENALTY=2, ex_redirect_i pulse -> one cycle of both flushes, then 2 cycles of PENALTY with if_id_flush_o=1, then RUN.
REQ-034 mem_busy_i=1 during PENALTY count 1 for 4 cycles -> all enables 0 for 4 cycles, then 1 PENALTY cycle, then RUN.
REQ-035 MEM_TIMEOUT=3, mem_busy_i=1 for 3 cycles -> err_o=1 after the third edge, held after busy drops, cleared only by rst_ni=0.
REQ-036 ex_redirect_i with a load-use match simultaneously -> redirect decode; with HAZARD_CTRL_PERF_EN, redirect_cnt_o=1 and stall_cnt_o=0.
